// File: rtl/slow_out_char.sv
// slow_out_char
// Slow-output character formatter for the typewriter/punch path.
// A rising edge of STB = T0 & OE & SLOW_OUT is one character event. The OF
// class decode and CH select an ASCII byte, which is queued in a small FIFO
// and presented to the host console link over a valid/ready handshake.
// Each host acceptance starts a pacing countdown that ends in a one-cycle
// TYPE_FB pulse back to the I/O control logic.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   PACE_CYCLES  cycles from host acceptance to TYPE_FB (>= 1)
// Optional build macro:
//   G15_OUT_PARITY_EN  when defined, TX_DATA[7] carries the XOR parity of
//                      TX_DATA[6:0], computed at encode time and stored in
//                      the FIFO; otherwise TX_DATA[7]=0 and 7 bits are stored.
//
// Ports:
//   CLOCK, rst_n        clock, asynchronous active-low reset
//   T0, OE, SLOW_OUT    strobe terms
//   DIGIT_OF, SIGN_OF,
//   CR_TAB_OF, WAIT_OF  OF character-class decode (priority top to bottom)
//   CH[3:0]             character code (OA4..OA1)
//   READY               clears OVERRUN and cancels pacing
//   TX_DATA, TX_VALID   FIFO head byte / FIFO not empty
//   TX_READY            host accepts on TX_VALID & TX_READY
//   BUSY                registered: FIFO count >= DEPTH-1
//   TYPE_FB             one-cycle paced typewriter feedback
//   OVERRUN             sticky: a byte was dropped on a full FIFO
module slow_out_char #(
  parameter int DEPTH       = 4,
  parameter int PACE_CYCLES = 16
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       T0,
  input  logic       OE,
  input  logic       SLOW_OUT,
  input  logic       DIGIT_OF,
  input  logic       SIGN_OF,
  input  logic       CR_TAB_OF,
  input  logic       WAIT_OF,
  input  logic [3:0] CH,
  input  logic       READY,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       BUSY,
  output logic       TYPE_FB,
  output logic       OVERRUN
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PACE_CYCLES + 1);
`ifdef G15_OUT_PARITY_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif

  typedef enum logic {ENC_IDLE, ENC_PUSH} enc_state_t;
  typedef enum logic {P_IDLE, P_CNT} pace_state_t;

  // Returns {has_byte, stored_byte}. Class priority: digit, sign, CR/TAB, wait.
  function automatic logic [SW:0] encode_char(
    input logic       dig,
    input logic       sgn,
    input logic       crt,
    input logic       wt,
    input logic [3:0] ch
  );
    logic [6:0] b;
    logic       has;
    b   = 7'h00;
    has = 1'b0;
    if (dig) begin
      has = 1'b1;
      // 0-9 -> '0'..'9'; 10-15 -> 'u'..'z' (0x6B + 10 = 0x75)
      b   = (ch < 4'd10) ? (7'h30 + {3'b000, ch}) : (7'h6B + {3'b000, ch});
    end else if (sgn) begin
      has = ch[0];
      b   = 7'h2D;
    end else if (crt) begin
      has = 1'b1;
      b   = ch[0] ? 7'h0D : 7'h09;
    end else if (wt) begin
      has = 1'b0;
      b   = 7'h00;
    end
`ifdef G15_OUT_PARITY_EN
    return {has, ^b, b};
`else
    return {has, b};
`endif
  endfunction

  logic             stb;
  logic             stb_d;
  logic             char_evt;
  logic [SW:0]      enc_word;
  enc_state_t       enc_state;
  logic             enc_has_p1;
  logic [SW-1:0]    enc_byte_p1;

  logic [SW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic [SW-1:0]    head;

  pace_state_t      pace_state;
  logic [PW-1:0]    pace_cnt;

  assign stb      = T0 & OE & SLOW_OUT;
  assign char_evt = stb & ~stb_d;
  assign enc_word = encode_char(DIGIT_OF, SIGN_OF, CR_TAB_OF, WAIT_OF, CH);

  // Stage p0 -> p1: character event captured into the encoder.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      stb_d      <= 1'b0;
      enc_state  <= ENC_IDLE;
      enc_has_p1 <= 1'b0;
    end else begin
      stb_d <= stb;
      case (enc_state)
        ENC_IDLE: begin
          if (char_evt) begin
            enc_has_p1 <= enc_word[SW];
            enc_state  <= ENC_PUSH;
          end
        end
        ENC_PUSH: begin
          enc_has_p1 <= 1'b0;
          enc_state  <= ENC_IDLE;
        end
        default: enc_state <= ENC_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (char_evt && enc_state == ENC_IDLE) begin
      enc_byte_p1 <= enc_word[SW-1:0];
    end
  end

  // Stage p1 -> FIFO: byte written during the ENC_PUSH cycle.
  assign full     = (count == CW'(DEPTH));
  assign TX_VALID = (count != '0);
  assign pop      = TX_VALID & TX_READY;
  assign push     = (enc_state == ENC_PUSH) & enc_has_p1;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en    = push & (~full | pop);

  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      mem[wr_ptr] <= enc_byte_p1;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      BUSY    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Registered from the current count, so it trails the count by a cycle.
      BUSY <= (count >= CW'(DEPTH - 1));
      if (READY) begin
        OVERRUN <= 1'b0;
      end else if (push && full && !pop) begin
        OVERRUN <= 1'b1;
      end
    end
  end

  assign head = mem[rd_ptr];
`ifdef G15_OUT_PARITY_EN
  assign TX_DATA = TX_VALID ? head : 8'h00;
`else
  assign TX_DATA = TX_VALID ? {1'b0, head} : 8'h00;
`endif

  // Pacing: pulse lands PACE_CYCLES cycles after the last acceptance. The
  // pulse is registered, so it is launched when the counter steps 1 -> 0.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      pace_state <= P_IDLE;
      pace_cnt   <= '0;
      TYPE_FB    <= 1'b0;
    end else begin
      TYPE_FB <= 1'b0;
      if (READY) begin
        pace_state <= P_IDLE;
      end else if (pop) begin
        if (PACE_CYCLES == 1) begin
          TYPE_FB    <= 1'b1;
          pace_state <= P_IDLE;
        end else begin
          pace_cnt   <= PW'(PACE_CYCLES - 1);
          pace_state <= P_CNT;
        end
      end else begin
        case (pace_state)
          P_IDLE: pace_state <= P_IDLE;
          P_CNT: begin
            pace_cnt <= pace_cnt - 1'b1;
            if (pace_cnt == PW'(1)) begin
              TYPE_FB    <= 1'b1;
              pace_state <= P_IDLE;
            end
          end
          default: pace_state <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slow_out_char.sv
// tb_slow_out_char
// Bench for slow_out_char (DEPTH=4, PACE_CYCLES=16). A behavioural model
// (byte queue, pending-encode slot, pulse-due cycle) tracks the expected
// outputs every cycle; directed phases follow the character, full-FIFO,
// pacing and reset scenarios, then a randomized phase runs.
module tb_slow_out_char;

  localparam int DEPTH = 4;
  localparam int PACE  = 16;

  logic       clk;
  logic       rst_n;
  logic       T0, OE, SLOW_OUT;
  logic       DIGIT_OF, SIGN_OF, CR_TAB_OF, WAIT_OF;
  logic [3:0] CH;
  logic       READY;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       BUSY;
  logic       TYPE_FB;
  logic       OVERRUN;

  slow_out_char #(.DEPTH(DEPTH), .PACE_CYCLES(PACE)) dut (
    .CLOCK(clk), .rst_n(rst_n), .T0(T0), .OE(OE), .SLOW_OUT(SLOW_OUT),
    .DIGIT_OF(DIGIT_OF), .SIGN_OF(SIGN_OF), .CR_TAB_OF(CR_TAB_OF),
    .WAIT_OF(WAIT_OF), .CH(CH), .READY(READY), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .BUSY(BUSY),
    .TYPE_FB(TYPE_FB), .OVERRUN(OVERRUN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] q_m[$];
  logic [7:0] acc_log[$];
  logic       pend_has;
  logic [7:0] pend_byte;
  bit         ovr_m, busy_m, stb_prev_m;
  int         due_m;
  int         cyc;
  int         pulses;
  int         fb_cycle;

  function automatic logic [7:0] par(input logic [7:0] b);
`ifdef G15_OUT_PARITY_EN
    return {^b[6:0], b[6:0]};
`else
    return {1'b0, b[6:0]};
`endif
  endfunction

  function automatic logic [8:0] ref_encode();
    string      digs;
    logic [7:0] b;
    logic       has;
    digs = "0123456789uvwxyz";
    has  = 1'b0;
    b    = 8'h00;
    if (DIGIT_OF) begin
      has = 1'b1; b = digs[int'(CH)];
    end else if (SIGN_OF) begin
      has = CH[0]; b = "-";
    end else if (CR_TAB_OF) begin
      has = 1'b1; b = CH[0] ? 8'h0D : 8'h09;
    end
    return {has, par(b)};
  endfunction

  task automatic model_reset();
    q_m.delete();
    pend_has   = 1'b0;
    pend_byte  = 8'h00;
    ovr_m      = 1'b0;
    busy_m     = 1'b0;
    stb_prev_m = 1'b0;
    due_m      = -1;
  endtask

  // Called right after each rising edge, with the inputs of the cycle that ended.
  task automatic model_step();
    int  sz;
    bit  pp, stb, evt;
    if (!rst_n) begin
      model_reset();
      cyc++;
      return;
    end
    sz = q_m.size();
    pp = (sz > 0) && TX_READY;
    if (pp) begin
      void'(q_m.pop_front());
      due_m = cyc + PACE;
    end
    if (pend_has) begin
      if (sz < DEPTH || pp) q_m.push_back(pend_byte);
      else ovr_m = 1'b1;
    end
    if (READY) begin
      ovr_m = 1'b0;
      due_m = -1;
    end
    busy_m = (sz >= DEPTH - 1);
    stb = T0 & OE & SLOW_OUT;
    evt = stb && !stb_prev_m;
    stb_prev_m = stb;
    {pend_has, pend_byte} = evt ? ref_encode() : 9'h000;
    cyc++;
  endtask

  task automatic check_outputs();
    check("tx_valid", TX_VALID, q_m.size() > 0);
    check("tx_data", TX_DATA, (q_m.size() > 0) ? q_m[0] : 8'h00);
    check("busy", BUSY, busy_m);
    check("overrun", OVERRUN, ovr_m);
    check("type_fb", TYPE_FB, due_m == cyc);
    if (TYPE_FB === 1'b1) begin
      pulses++;
      fb_cycle = cyc;
    end
  endtask

  task automatic tick();
    if (TX_VALID === 1'b1 && TX_READY === 1'b1) acc_log.push_back(TX_DATA);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // cls: 0 digit, 1 sign, 2 cr/tab, 3 wait, other none
  task automatic send(input int cls, input logic [3:0] ch, input int hold);
    DIGIT_OF  = (cls == 0);
    SIGN_OF   = (cls == 1);
    CR_TAB_OF = (cls == 2);
    WAIT_OF   = (cls == 3);
    CH = ch; T0 = 1'b1; OE = 1'b1; SLOW_OUT = 1'b1;
    repeat (hold) tick();
    T0 = 1'b0;
    tick();
  endtask

  task automatic drain(input int n);
    TX_READY = 1'b1;
    repeat (n) tick();
    TX_READY = 1'b0;
  endtask

  int a2;
  int rdy_bias;

  initial begin
    cyc = 0; pulses = 0; fb_cycle = -1;
    model_reset();
    rst_n = 1'b0; T0 = 0; OE = 0; SLOW_OUT = 0;
    DIGIT_OF = 0; SIGN_OF = 0; CR_TAB_OF = 0; WAIT_OF = 0;
    CH = 4'h0; READY = 0; TX_READY = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx_data", TX_DATA, 8'h00);
    check("rst_tx_valid", TX_VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_type_fb", TYPE_FB, 1'b0);
    check("rst_overrun", OVERRUN, 1'b0);
    rst_n = 1'b1;
    tick();

    // Digit path
    TX_READY = 1'b1;
    acc_log.delete();
    send(0, 4'h3, 1);
    send(0, 4'hC, 2);
    repeat (4) tick();
    check("digit_count", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      check("digit_3", acc_log[0], par(8'h33));
      check("digit_c", acc_log[1], par(8'h77));
    end

    // Sign and format
    acc_log.delete();
    send(1, 4'h1, 1);
    send(1, 4'h0, 1);
    send(2, 4'h1, 3);
    send(2, 4'h0, 1);
    send(3, 4'h5, 1);
    send(4, 4'h7, 1);
    repeat (4) tick();
    check("fmt_count", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      check("fmt_minus", acc_log[0], par(8'h2D));
      check("fmt_cr", acc_log[1], par(8'h0D));
      check("fmt_tab", acc_log[2], par(8'h09));
    end
    TX_READY = 1'b0;
    repeat (20) tick();

    // Full FIFO and overrun
    for (int i = 0; i <= DEPTH; i++) send(0, 4'(i), 1);
    tick();
    check("full_busy", BUSY, 1'b1);
    check("full_overrun", OVERRUN, 1'b1);
    check("full_head", TX_DATA, par(8'h30));
    READY = 1'b1;
    tick();
    READY = 1'b0;
    check("ready_clr_overrun", OVERRUN, 1'b0);
    check("ready_keeps_head", TX_DATA, par(8'h30));
    acc_log.delete();
    drain(DEPTH + 2);
    check("full_drain_count", acc_log.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < acc_log.size(); i++)
      check("full_drain_byte", acc_log[i], par(8'h30 + 8'(i)));
    repeat (20) tick();

    // Push and pop together on a full FIFO
    for (int i = 0; i < DEPTH; i++) send(0, 4'(5 + i), 1);
    tick();
    acc_log.delete();
    DIGIT_OF = 1'b1; SIGN_OF = 0; CR_TAB_OF = 0; WAIT_OF = 0; CH = 4'h9;
    T0 = 1'b1;
    tick();
    T0 = 1'b0;
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    tick();
    check("pp_overrun", OVERRUN, 1'b0);
    check("pp_busy", BUSY, 1'b1);
    check("pp_head", TX_DATA, par(8'h36));
    drain(DEPTH + 2);
    check("pp_count", acc_log.size(), DEPTH + 1);
    for (int i = 0; i <= DEPTH && i < acc_log.size(); i++)
      check("pp_order", acc_log[i], par(8'h35 + 8'(i)));
    repeat (20) tick();

    // Pacing: two acceptances five cycles apart, one pulse
    send(0, 4'h1, 1);
    send(0, 4'h2, 1);
    tick();
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    repeat (4) tick();
    a2 = cyc;
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    pulses = 0; fb_cycle = -1;
    repeat (25) tick();
    check("pace_pulses", pulses, 1);
    check("pace_cycle", fb_cycle, a2 + PACE);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) rdy_bias = $urandom_range(0, 4);
      T0        = ($urandom_range(0, 2) == 0);
      OE        = ($urandom_range(0, 7) != 0);
      SLOW_OUT  = ($urandom_range(0, 9) != 0);
      DIGIT_OF  = $urandom_range(0, 1);
      SIGN_OF   = $urandom_range(0, 1);
      CR_TAB_OF = $urandom_range(0, 1);
      WAIT_OF   = $urandom_range(0, 1);
      CH        = 4'($urandom_range(0, 15));
      TX_READY  = ($urandom_range(0, 3) < rdy_bias);
      READY     = ($urandom_range(0, 59) == 0);
      tick();
    end
    T0 = 1'b0; READY = 1'b0; TX_READY = 1'b0;
    repeat (20) tick();

    // Asynchronous reset with bytes queued and OVERRUN set
    for (int i = 0; i <= DEPTH; i++) send(0, 4'(i), 1);
    tick();
    check("pre_rst_overrun", OVERRUN, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", TX_VALID, 1'b0);
    check("async_rst_overrun", OVERRUN, 1'b0);
    check("async_rst_data", TX_DATA, 8'h00);
    check("async_rst_busy", BUSY, 1'b0);
    model_reset();
    tick();
    rst_n = 1'b1;
    TX_READY = 1'b1;
    send(0, 4'h7, 1);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
